// File: rtl/tick_capture_pkg.sv
// Shared types and default sizes for the tick interval capture block.
package tick_capture_pkg;

  // Measurement FSM: waiting for a start, or holding a start and waiting for its end.
  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_e;

  localparam int unsigned TW_DEF    = 32;
  localparam int unsigned IDW_DEF   = 4;
  localparam int unsigned DEPTH_DEF = 4;
  localparam int unsigned ORPHAN_W  = 8;

  localparam logic [ORPHAN_W-1:0] ORPHAN_MAX = 8'hFF;

endpackage

// File: rtl/tick_fifo.sv
// Synchronous show-ahead FIFO; dout presents the head entry whenever empty is low.
// DEPTH must be a power of two and at least 2.
module tick_fifo #(
  parameter int unsigned W     = 36,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic          do_push;
  logic          do_pop;

  // A pop frees a slot in the same cycle, so a push into a full FIFO succeeds alongside it.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
  end

  // Storage and pointers; the extra pointer bit distinguishes full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_q[AW-1:0]] <= din;
        wr_q              <= wr_q + PW'(1);
      end
      if (do_pop) begin
        rd_q <= rd_q + PW'(1);
      end
    end
  end

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout  = mem[rd_q[AW-1:0]];

endmodule

// File: rtl/tick_interval_capture.sv
// Captures start/end cycle counts, queues tagged elapsed-cycle intervals for a host.
// Optional macro TICK_CAPTURE_MAXHOLD_EN adds a running maximum output max_interval.
module tick_interval_capture
  import tick_capture_pkg::*;
#(
  parameter int unsigned TW    = TW_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned IDW   = IDW_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [TW-1:0]       ticks,
  input  logic                start,
  input  logic                end_ev,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [TW-1:0]       out_interval,
  output logic [IDW-1:0]      out_id,
  output logic                armed,
  output logic                overflow,
`ifdef TICK_CAPTURE_MAXHOLD_EN
  output logic [TW-1:0]       max_interval,
`endif
  output logic [ORPHAN_W-1:0] orphan_cnt
);

  localparam int unsigned RW = TW + IDW;

  state_e                state_q;
  state_e                state_d;
  logic [TW-1:0]         t0_q;
  logic [IDW-1:0]        seq_q;
  logic [ORPHAN_W-1:0]   orphan_q;
  logic                  overflow_q;
  logic [TW-1:0]         interval_c;
  logic                  push_c;
  logic                  latch_c;
  logic                  orphan_inc_c;
  logic                  pop_c;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [RW-1:0]         fifo_din;
  logic [RW-1:0]         fifo_dout;

  // Modular subtraction keeps the interval correct across a counter wrap.
  assign interval_c = ticks - t0_q;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a start always (re)arms; an end without a simultaneous start disarms.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ARMED;
      ARMED:   if (end_ev && !start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM actions: an end while idle is an orphan; an end while armed produces a result.
  always_comb begin
    push_c       = 1'b0;
    latch_c      = 1'b0;
    orphan_inc_c = 1'b0;
    case (state_q)
      IDLE: begin
        latch_c      = start;
        orphan_inc_c = end_ev;
      end
      ARMED: begin
        push_c  = end_ev;
        latch_c = start;
      end
      default: ;
    endcase
  end

  // Start timestamp.
  always_ff @(posedge clk) begin
    if (rst) begin
      t0_q <= '0;
    end else if (latch_c) begin
      t0_q <= ticks;
    end
  end

  // Sequence tag advances on every result, dropped or not, so drops show as tag gaps.
  always_ff @(posedge clk) begin
    if (rst) begin
      seq_q <= '0;
    end else if (push_c) begin
      seq_q <= seq_q + IDW'(1);
    end
  end

  // Saturating count of unmatched end events.
  always_ff @(posedge clk) begin
    if (rst) begin
      orphan_q <= '0;
    end else if (orphan_inc_c && (orphan_q != ORPHAN_MAX)) begin
      orphan_q <= orphan_q + ORPHAN_W'(1);
    end
  end

  // Sticky drop flag: a result arrived while full with no pop to make room.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else if (push_c && fifo_full && !pop_c) begin
      overflow_q <= 1'b1;
    end
  end

`ifdef TICK_CAPTURE_MAXHOLD_EN
  logic [TW-1:0] max_q;

  // Largest interval measured, including results the FIFO could not hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      max_q <= '0;
    end else if (push_c && (interval_c > max_q)) begin
      max_q <= interval_c;
    end
  end

  assign max_interval = max_q;
`endif

  assign pop_c    = out_valid && out_ready;
  assign fifo_din = {seq_q, interval_c};

  tick_fifo #(
    .W     (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_c),
    .pop   (pop_c),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_valid    = !fifo_empty;
  assign out_interval = fifo_dout[TW-1:0];
  assign out_id       = fifo_dout[RW-1:TW];
  assign armed        = (state_q == ARMED);
  assign overflow     = overflow_q;
  assign orphan_cnt   = orphan_q;

endmodule

// File: tb/tb_tick_interval_capture.sv
// Directed bench for tick_interval_capture: vector table plus multi-cycle corner sequences.
module tb_tick_interval_capture;

  logic        clk;
  logic        rst;
  logic [31:0] ticks;
  logic        start;
  logic        end_ev;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_interval;
  logic [3:0]  out_id;
  logic        armed;
  logic        overflow;
  logic [7:0]  orphan_cnt;
`ifdef TICK_CAPTURE_MAXHOLD_EN
  logic [31:0] max_interval;
`endif

  int checks;
  int failures;

  tick_interval_capture dut (
    .clk          (clk),
    .rst          (rst),
    .ticks        (ticks),
    .start        (start),
    .end_ev       (end_ev),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_interval (out_interval),
    .out_id       (out_id),
    .armed        (armed),
    .overflow     (overflow),
`ifdef TICK_CAPTURE_MAXHOLD_EN
    .max_interval (max_interval),
`endif
    .orphan_cnt   (orphan_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic        e;
    logic [31:0] t;
    logic        r;
    logic        v;
    logic [31:0] iv;
    logic [3:0]  id;
    logic        a;
    logic [7:0]  orph;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Apply inputs, take one rising edge, and settle 1 time unit past it.
  task automatic step(input logic s, input logic e, input logic [31:0] t, input logic r);
    start     = s;
    end_ev    = e;
    ticks     = t;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 1'b0, 32'd0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic chk_head(input string name, input logic [31:0] iv, input logic [3:0] id);
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_interval"}, out_interval, iv);
    chk({name, "_id"}, 32'(out_id), 32'(id));
  endtask

  int unsigned ival_a[5];
  int unsigned drain_iv[4];
  int unsigned drain_id[4];
  int unsigned ival_d[3];

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    start    = 1'b0;
    end_ev   = 1'b0;
    ticks    = '0;
    out_ready = 1'b0;

    // s, e, ticks, ready, exp_valid, exp_interval, exp_id, exp_armed, exp_orphan
    vecs[0]  = '{1'b0, 1'b0, 32'd99,         1'b1, 1'b0, 32'd0,  4'd0, 1'b0, 8'd0};
    vecs[1]  = '{1'b1, 1'b0, 32'd100,        1'b1, 1'b0, 32'd0,  4'd0, 1'b1, 8'd0};
    vecs[2]  = '{1'b0, 1'b1, 32'd157,        1'b1, 1'b1, 32'd57, 4'd0, 1'b0, 8'd0};
    vecs[3]  = '{1'b0, 1'b0, 32'd158,        1'b1, 1'b0, 32'd0,  4'd0, 1'b0, 8'd0};
    vecs[4]  = '{1'b1, 1'b0, 32'hFFFF_FFF0,  1'b1, 1'b0, 32'd0,  4'd0, 1'b1, 8'd0};
    vecs[5]  = '{1'b0, 1'b1, 32'h0000_0010,  1'b1, 1'b1, 32'd32, 4'd1, 1'b0, 8'd0};
    vecs[6]  = '{1'b0, 1'b0, 32'd20,         1'b1, 1'b0, 32'd0,  4'd0, 1'b0, 8'd0};
    vecs[7]  = '{1'b0, 1'b1, 32'd21,         1'b1, 1'b0, 32'd0,  4'd0, 1'b0, 8'd1};
    vecs[8]  = '{1'b0, 1'b1, 32'd22,         1'b1, 1'b0, 32'd0,  4'd0, 1'b0, 8'd2};
    vecs[9]  = '{1'b0, 1'b1, 32'd23,         1'b1, 1'b0, 32'd0,  4'd0, 1'b0, 8'd3};
    vecs[10] = '{1'b1, 1'b1, 32'd200,        1'b1, 1'b0, 32'd0,  4'd0, 1'b1, 8'd4};
    vecs[11] = '{1'b0, 1'b1, 32'd205,        1'b1, 1'b1, 32'd5,  4'd2, 1'b0, 8'd4};
    vecs[12] = '{1'b0, 1'b0, 32'd206,        1'b1, 1'b0, 32'd0,  4'd0, 1'b0, 8'd4};

    // Reset state
    do_reset();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_interval", out_interval, 32'd0);
    chk("rst_id", 32'(out_id), 32'd0);
    chk("rst_armed", 32'(armed), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_orphan", 32'(orphan_cnt), 32'd0);
`ifdef TICK_CAPTURE_MAXHOLD_EN
    chk("rst_max", max_interval, 32'd0);
`endif

    // Table: basic measurement, wrap-around, orphans, simultaneous start/end in idle
    for (int i = 0; i < 13; i++) begin
      step(vecs[i].s, vecs[i].e, vecs[i].t, vecs[i].r);
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].v));
      chk($sformatf("vec%0d_armed", i), 32'(armed), 32'(vecs[i].a));
      chk($sformatf("vec%0d_orphan", i), 32'(orphan_cnt), 32'(vecs[i].orph));
      if (vecs[i].v) begin
        chk($sformatf("vec%0d_interval", i), out_interval, vecs[i].iv);
        chk($sformatf("vec%0d_id", i), 32'(out_id), 32'(vecs[i].id));
      end
    end

    // Overflow: fill with ready low, drop the fifth, then push and pop together while full
    do_reset();
    ival_a = '{1, 2, 3, 4, 50};
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 32'(1000 * (i + 1)), 1'b0);
      step(1'b0, 1'b1, 32'(1000 * (i + 1)) + 32'(ival_a[i]), 1'b0);
    end
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk_head("ovf_head", 32'd1, 4'd0);
    step(1'b1, 1'b0, 32'd9000, 1'b0);
    step(1'b0, 1'b1, 32'd9007, 1'b1);
    drain_iv = '{2, 3, 4, 7};
    drain_id = '{1, 2, 3, 5};
    for (int k = 0; k < 4; k++) begin
      chk_head($sformatf("drain%0d", k), 32'(drain_iv[k]), 4'(drain_id[k]));
      step(1'b0, 1'b0, 32'd9100, 1'b1);
    end
    chk("drained_valid", 32'(out_valid), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);
`ifdef TICK_CAPTURE_MAXHOLD_EN
    chk("max_incl_dropped", max_interval, 32'd50);
`endif

    // Reset while armed with queued results and nonzero counters
    step(1'b0, 1'b1, 32'd9200, 1'b0);
    step(1'b1, 1'b0, 32'd9300, 1'b0);
    step(1'b0, 1'b1, 32'd9311, 1'b0);
    step(1'b1, 1'b0, 32'd9400, 1'b0);
    step(1'b0, 1'b1, 32'd9422, 1'b0);
    step(1'b1, 1'b0, 32'd9500, 1'b0);
    chk("pre_rst_armed", 32'(armed), 32'd1);
    chk("pre_rst_orphan", 32'(orphan_cnt), 32'd1);
    chk_head("pre_rst_head", 32'd11, 4'd6);
    do_reset();
    chk("mid_rst_armed", 32'(armed), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_overflow", 32'(overflow), 32'd0);
    chk("mid_rst_orphan", 32'(orphan_cnt), 32'd0);
    chk("mid_rst_interval", out_interval, 32'd0);

    // Sequence tag restarts after reset; running maximum over 9, 40, 90, 15
    step(1'b1, 1'b0, 32'd50, 1'b0);
    step(1'b0, 1'b1, 32'd59, 1'b0);
    chk_head("post_rst", 32'd9, 4'd0);
    ival_d = '{40, 90, 15};
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 32'(100 * (i + 1)), 1'b0);
      step(1'b0, 1'b1, 32'(100 * (i + 1)) + 32'(ival_d[i]), 1'b0);
    end
    chk_head("held_head", 32'd9, 4'd0);
    chk("full_no_ovf", 32'(overflow), 32'd0);
`ifdef TICK_CAPTURE_MAXHOLD_EN
    chk("max_90", max_interval, 32'd90);
`endif

    // Start and end together while armed: push to now, re-arm at now
    do_reset();
    step(1'b1, 1'b0, 32'd10, 1'b0);
    step(1'b1, 1'b1, 32'd30, 1'b0);
    chk("sim_armed", 32'(armed), 32'd1);
    chk_head("sim_first", 32'd20, 4'd0);
    step(1'b0, 1'b1, 32'd45, 1'b0);
    chk("sim_disarmed", 32'(armed), 32'd0);
    chk_head("sim_head_hold", 32'd20, 4'd0);
    step(1'b0, 1'b0, 32'd46, 1'b1);
    chk_head("sim_second", 32'd15, 4'd1);
    step(1'b0, 1'b0, 32'd47, 1'b1);
    chk("sim_empty", 32'(out_valid), 32'd0);
    chk("sim_orphan", 32'(orphan_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
